// File: rtl/sram_arbiter.sv
// Round-robin arbiter and sequencer sharing one 128x9 single-port SRAM between two requesters,
// with a zero-fill clear sequence after reset or on command.
module sram_arbiter #(
    parameter int unsigned ADDR_W         = 7,
    parameter int unsigned DATA_W         = 9,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_req,
    output logic              busy,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_ce,
    output logic              mem_wre,
    output logic              mem_oce,
    output logic              mem_reset,
    output logic [ADDR_W-1:0] mem_ad,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic {
        SERVE = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t              state, state_nx;
    logic                rr_ptr, rr_nx;
    logic                gnt_vld, gnt_port;
    logic                busy_nx;
    logic [ADDR_W-1:0]   clr_cnt, clr_cnt_nx;
    logic                ce_nx, wre_nx;
    logic [ADDR_W-1:0]   ad_nx;
    logic [DATA_W-1:0]   din_nx;
    // Read tracking: s1 = issued to SRAM this cycle, s2 = SRAM data out valid this cycle
    logic                s1_vld, s1_port, s2_vld, s2_port;
    logic                s1_vld_nx, s1_port_nx;

    assign mem_oce   = 1'b1;
    assign mem_reset = 1'b0;

    // Acks are combinational and suppressed while reset is held
    assign ack0 = reset & gnt_vld & ~gnt_port;
    assign ack1 = reset & gnt_vld & gnt_port;

    // Next-state, grant and SRAM pin decode
    always_comb begin
        state_nx   = state;
        rr_nx      = rr_ptr;
        clr_cnt_nx = clr_cnt;
        gnt_vld    = 1'b0;
        gnt_port   = 1'b0;
        ce_nx      = 1'b0;
        wre_nx     = 1'b0;
        ad_nx      = mem_ad;
        din_nx     = mem_din;
        s1_vld_nx  = 1'b0;
        s1_port_nx = 1'b0;

        case (state)
            SERVE: begin
                if (req0 && req1) begin
                    gnt_vld  = 1'b1;
                    gnt_port = ~rr_ptr;
                end else if (req0) begin
                    gnt_vld  = 1'b1;
                    gnt_port = 1'b0;
                end else if (req1) begin
                    gnt_vld  = 1'b1;
                    gnt_port = 1'b1;
                end

                if (gnt_vld) begin
                    rr_nx      = gnt_port;
                    ce_nx      = 1'b1;
                    wre_nx     = gnt_port ? we1 : we0;
                    ad_nx      = gnt_port ? addr1 : addr0;
                    din_nx     = gnt_port ? wdata1 : wdata0;
                    s1_vld_nx  = ~wre_nx;
                    s1_port_nx = gnt_port;
                end

                if (clear_req) begin
                    state_nx = CLEAR;
                end
            end

            CLEAR: begin
                ce_nx      = 1'b1;
                wre_nx     = 1'b1;
                ad_nx      = clr_cnt;
                din_nx     = '0;
                clr_cnt_nx = ADDR_W'(clr_cnt + 1'b1);
                if (clr_cnt == LAST_ADDR) begin
                    state_nx = SERVE;
                end
            end

            default: begin
                state_nx = SERVE;
            end
        endcase

        busy_nx = (state_nx == CLEAR);
    end

    // State, SRAM pin and read-return registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= CLEAR_ON_RESET ? CLEAR : SERVE;
            busy    <= CLEAR_ON_RESET;
            rr_ptr  <= 1'b1;
            clr_cnt <= '0;
            mem_ce  <= 1'b0;
            mem_wre <= 1'b0;
            mem_ad  <= '0;
            mem_din <= '0;
            s1_vld  <= 1'b0;
            s1_port <= 1'b0;
            s2_vld  <= 1'b0;
            s2_port <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            state   <= state_nx;
            busy    <= busy_nx;
            rr_ptr  <= rr_nx;
            clr_cnt <= clr_cnt_nx;
            mem_ce  <= ce_nx;
            mem_wre <= wre_nx;
            mem_ad  <= ad_nx;
            mem_din <= din_nx;
            s1_vld  <= s1_vld_nx;
            s1_port <= s1_port_nx;
            s2_vld  <= s1_vld;
            s2_port <= s1_port;
            rvalid0 <= s2_vld & ~s2_port;
            rvalid1 <= s2_vld & s2_port;
            if (s2_vld && !s2_port) begin
                rdata0 <= mem_dout;
            end
            if (s2_vld && s2_port) begin
                rdata1 <= mem_dout;
            end
        end
    end

endmodule
